// File: rtl/mem_pkg.sv
// Shared types and defaults for the word-addressed main memory behind the MAR/MDR pair.
// Consumers: mem_subsystem, mem_array.
package mem_pkg;

  localparam int unsigned DefaultDataWidth  = 32;
  localparam int unsigned DefaultAddrBits   = 9;
  localparam int unsigned DefaultWaitStates = 2;
  localparam int unsigned CntWidth          = 4;

  // FSM encoding kept as plain constants so legacy code can compare raw state bits.
  typedef logic [1:0] mem_state_t;
  localparam mem_state_t StIdle   = 2'd0;
  localparam mem_state_t StAccess = 2'd1;
  localparam mem_state_t StDone   = 2'd2;

endpackage

// File: rtl/mem_array.sv
// Single-port DEPTH x DATA_WIDTH storage with synchronous write and registered read.
// Deliberately unreset: contents and the read register are undefined until loaded.
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned ADDR_BITS  = DefaultAddrBits
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_subsystem.sv
// Main memory with wait states and a 4-phase ready handshake (IDLE -> ACCESS -> DONE).
// Optional address range checking is enabled by defining MEM_BOUNDS_EN.
module mem_subsystem
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DefaultDataWidth,
  parameter int unsigned ADDR_BITS   = DefaultAddrBits,
  parameter int unsigned WAIT_STATES = DefaultWaitStates
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [31:0]           mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_read,
  input  logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_ready,
  output logic                  mem_busy,
  output logic                  mem_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;

  mem_state_t            state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  is_write_q, is_write_d;
  logic                  oob_q, oob_d;
  logic                  rdata_vld_q, rdata_vld_d;
  logic                  commit;
  logic                  req_oob;
  logic                  array_we, array_re;
  logic [DATA_WIDTH-1:0] array_rdata;

`ifdef MEM_BOUNDS_EN
  assign req_oob = (mem_addr >= 32'(DEPTH));
`else
  // Upper address bits alias onto the low index without range checking.
  logic unused_addr_hi;
  assign unused_addr_hi = ^mem_addr[31:ADDR_BITS];
  assign req_oob        = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    is_write_d  = is_write_q;
    oob_d       = oob_q;
    rdata_vld_d = rdata_vld_q;
    commit      = 1'b0;
    case (state_q)
      StIdle: begin
        if (mem_write || mem_read) begin
          state_d    = StAccess;
          cnt_d      = CntWidth'(WAIT_STATES);
          addr_d     = mem_addr[ADDR_BITS-1:0];
          wdata_d    = mem_wdata;
          is_write_d = mem_write;
          oob_d      = req_oob;
        end
      end
      StAccess: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = StDone;
          commit  = 1'b1;
          // An out-of-range read presents zero instead of the array output.
          if (!is_write_q) begin
            rdata_vld_d = !oob_q;
          end
        end
      end
      StDone: begin
        if (!mem_read && !mem_write) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      is_write_q  <= 1'b0;
      oob_q       <= 1'b0;
      rdata_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      is_write_q  <= is_write_d;
      oob_q       <= oob_d;
      rdata_vld_q <= rdata_vld_d;
    end
  end

  assign array_we = commit && is_write_q && !oob_q && !clear;
  assign array_re = commit && !is_write_q && !oob_q && !clear;

  mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (ADDR_BITS)
  ) u_mem_array (
    .clock (clock),
    .we    (array_we),
    .re    (array_re),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (array_rdata)
  );

  // The unreset read register only becomes visible once a real read has loaded it.
  assign mem_rdata = rdata_vld_q ? array_rdata : '0;
  assign mem_ready = (state_q == StDone);
  assign mem_busy  = (state_q != StIdle);
  assign mem_err   = (state_q == StDone) && oob_q;

endmodule

// File: tb/tb_mem_subsystem.sv
// Randomized scoreboard bench for mem_subsystem; expectations come from an array model.
// Compile with MEM_BOUNDS_EN defined to check the range-checking build.
module tb_mem_subsystem;

  localparam int unsigned DW    = 32;
  localparam int unsigned AB    = 9;
  localparam int unsigned WS    = 2;
  localparam int unsigned DEPTH = 2 ** AB;

`ifdef MEM_BOUNDS_EN
  localparam bit BoundsOn = 1'b1;
`else
  localparam bit BoundsOn = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          clear;
  logic [31:0]   mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          mem_busy;
  logic          mem_err;

  mem_subsystem #(
    .DATA_WIDTH  (DW),
    .ADDR_BITS   (AB),
    .WAIT_STATES (WS)
  ) dut (
    .clock     (clock),
    .clear     (clear),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .mem_busy  (mem_busy),
    .mem_err   (mem_err)
  );

  always #5 clock = ~clock;

  int cycle = 0;
  always @(posedge clock) cycle++;

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cycle);
    end else begin
      passed++;
    end
  endtask

  // Reference model: word store with per-word "ever written" flags and the held read value.
  logic [DW-1:0] model_mem   [DEPTH];
  bit            model_known [DEPTH];
  logic [DW-1:0] model_rdata;
  bit            model_rknown;

  typedef struct {
    logic [DW-1:0] rdata;
    bit            rknown;
    bit            err;
    int            ready_cycle;
  } exp_t;

  exp_t exp_q[$];

  function automatic exp_t model_op(input bit wr, input logic [31:0] addr, input logic [DW-1:0] wd,
                                    input int sample_cycle);
    exp_t e;
    bit oob;
    int idx;
    oob = BoundsOn && (addr >= DEPTH);
    idx = int'(addr % DEPTH);
    if (wr) begin
      if (!oob) begin
        model_mem[idx]   = wd;
        model_known[idx] = 1'b1;
      end
    end else if (oob) begin
      model_rdata  = '0;
      model_rknown = 1'b1;
    end else begin
      model_rdata  = model_mem[idx];
      model_rknown = model_known[idx];
    end
    e.rdata       = model_rdata;
    e.rknown      = model_rknown;
    e.err         = oob;
    e.ready_cycle = sample_cycle + int'(WS) + 1;
    return e;
  endfunction

  // Monitor: every rising edge of ready is one completed transaction.
  logic prev_ready = 1'b0;
  always @(negedge clock) begin
    exp_t e;
    if (clear !== 1'b0) begin
      prev_ready <= 1'b0;
    end else begin
      if (mem_ready === 1'b1 && prev_ready !== 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ready", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("ready_latency", 32'(cycle), 32'(e.ready_cycle));
          check("err_in_done", {31'd0, mem_err}, {31'd0, e.err});
          check("busy_in_done", {31'd0, mem_busy}, 32'd1);
          if (e.rknown) check("rdata", mem_rdata, e.rdata);
        end
      end else if (mem_ready !== 1'b1) begin
        if (mem_err !== 1'b0) check("err_outside_done", {31'd0, mem_err}, 32'd0);
      end
      prev_ready <= mem_ready;
    end
  end

  task automatic do_op(input bit wr, input bit rd, input logic [31:0] addr,
                       input logic [DW-1:0] wd);
    bit got;
    int hold;
    @(negedge clock);
    mem_write = wr;
    mem_read  = rd;
    mem_addr  = addr;
    mem_wdata = wd;
    exp_q.push_back(model_op(wr, addr, wd, cycle + 1));
    @(posedge clock);
    #1;
    // Latched values only: scramble the buses after the sampling edge.
    mem_addr  = $urandom;
    mem_wdata = $urandom;
    @(negedge clock);
    check("busy_after_sample", {31'd0, mem_busy}, 32'd1);
    check("ready_early", {31'd0, mem_ready}, 32'd0);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mem_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (!got) begin
      check("ready_timeout", 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end
    hold = $urandom_range(0, 2);
    repeat (hold) begin
      @(negedge clock);
      check("ready_hold", {31'd0, mem_ready}, 32'd1);
    end
    mem_write = 1'b0;
    mem_read  = 1'b0;
    @(negedge clock);
    check("ready_fall", {31'd0, mem_ready}, 32'd0);
    check("busy_fall", {31'd0, mem_busy}, 32'd0);
  endtask

  task automatic do_abort(input logic [31:0] addr, input logic [DW-1:0] wd);
    @(negedge clock);
    mem_write = 1'b1;
    mem_addr  = addr;
    mem_wdata = wd;
    @(negedge clock);
    check("abort_busy", {31'd0, mem_busy}, 32'd1);
    clear     = 1'b1;
    mem_write = 1'b0;
    @(negedge clock);
    clear        = 1'b0;
    model_rdata  = '0;
    model_rknown = 1'b1;
    check("abort_busy_cleared", {31'd0, mem_busy}, 32'd0);
    check("abort_ready_cleared", {31'd0, mem_ready}, 32'd0);
    check("abort_rdata_cleared", mem_rdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addr;
    int sel;
    for (int i = 0; i < int'(DEPTH); i++) model_known[i] = 1'b0;
    model_rdata  = '0;
    model_rknown = 1'b1;

    clear     = 1'b1;
    mem_read  = 1'b1;
    mem_write = 1'b1;
    mem_addr  = 32'h54;
    mem_wdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_rdata", mem_rdata, 32'd0);
    check("reset_ready", {31'd0, mem_ready}, 32'd0);
    check("reset_busy", {31'd0, mem_busy}, 32'd0);
    check("reset_err", {31'd0, mem_err}, 32'd0);
    clear     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clock);
    check("idle_after_reset", {31'd0, mem_busy}, 32'd0);

    do_op(1'b1, 1'b0, 32'h54, 32'h0000_00A5);
    do_op(1'b0, 1'b1, 32'h54, 32'h0);
    do_op(1'b1, 1'b0, 32'h55, 32'h1111_1111);
    do_op(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    do_op(1'b0, 1'b1, 32'h10, 32'h0);
    do_op(1'b1, 1'b0, 32'h20, 32'hCAFE_F00D);
    do_abort(32'h20, 32'h1234_5678);
    do_op(1'b0, 1'b1, 32'h20, 32'h0);
    do_op(1'b0, 1'b1, 32'h254, 32'h0);

    for (int i = 0; i < 8; i++) do_op(1'b1, 1'b0, 32'h40 + 32'(i), $urandom);

    for (int n = 0; n < 120; n++) begin
      addr = 32'h40 + 32'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        1: addr = addr | 32'h200;
        2: addr = addr | 32'h0001_0000;
        3: addr = 32'h54 | ($urandom_range(0, 1) ? 32'h200 : 32'h0);
        default: ;
      endcase
      sel = int'($urandom_range(0, 3));
      do_op(sel <= 1 || sel == 3, sel >= 2, addr, $urandom);
    end

    repeat (3) @(negedge clock);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_subsystem.md
Name: mem_subsystem

Overview:
- Word-addressed main memory sitting directly downstream of the datapath's MAR/MDR pair.
- Consumes the MAR address, the MDR write data and the read/write strobes from control.
- Returns read data on the lines that feed the MDR's Mdatain input.
- Multi-cycle access with configurable wait states and a 4-phase ready handshake, so control can stall on memory.

Parameters:
- DATA_WIDTH, 32: word width in bits.
- ADDR_BITS, 9: index width; DEPTH = 2**ADDR_BITS words (512 by default), derived locally.
- WAIT_STATES, 2: extra cycles spent in ACCESS before an operation commits; legal range 0..15.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- clear  in  1  synchronous, active-high reset.
- mem_addr  in  32  word address, driven from the MAR output.
- mem_wdata  in  DATA_WIDTH  write data, driven from the MDR output.
- mem_read  in  1  read request, level-sensitive.
- mem_write  in  1  write request, level-sensitive.
- mem_rdata  out  DATA_WIDTH  read data, driven to MDR Mdatain.
- mem_ready  out  1  operation complete; high only in DONE.
- mem_busy  out  1  high in ACCESS and DONE.
- mem_err  out  1  address fault; see Optional Feature.

Behaviour:
- Clock and reset: one clock, clock; reset is synchronous and active-high, clear.
- Reset values: state IDLE, mem_rdata 0, mem_ready 0, mem_busy 0, mem_err 0, wait counter 0.
- Reset does not clear the memory array; contents are undefined until written.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If mem_write or mem_read is high at a rising edge, latch mem_addr, mem_wdata and the op.
  - Load the counter with WAIT_STATES, then go to ACCESS.
  - If both strobes are high, write has priority; the read is dropped for this transaction.
- ACCESS:
  - Counter nonzero: decrement it and stay in ACCESS.
  - Counter zero: commit the op and go to DONE.
    - Write: array[addr_latched[ADDR_BITS-1:0]] <= wdata_latched.
    - Read: mem_rdata <= array[index].
- Latency: DONE is entered WAIT_STATES+1 cycles after the request-sampling edge. With WAIT_STATES=0, ready rises on the second edge after the request.
- DONE:
  - mem_ready is high.
  - Stay until mem_read and mem_write are both low, then return to IDLE (4-phase handshake).
  - A new request needs at least one IDLE cycle.
- mem_rdata holds its value until the next read commits; writes never change it.
- Input changes during ACCESS or DONE are ignored; only the latched values are used.
- Clear mid-operation: abort, no write commits, outputs take their reset values.
- Clear asserted together with a request: clear wins, and the request is not sampled.
- Without bounds checking, address bits above ADDR_BITS-1 are ignored, so addresses wrap/alias.

Optional Feature:
- Macro: MEM_BOUNDS_EN.
- Defined:
  - At the IDLE->ACCESS transition, flag the transaction out-of-range if mem_addr >= DEPTH.
  - At commit, an out-of-range transaction skips the array access; a read loads mem_rdata with 0.
  - mem_err is 1 throughout DONE for that transaction and 0 otherwise.
  - Timing is unchanged.
- Undefined: no range compare, addresses alias via the low ADDR_BITS, and mem_err is tied 0.

Decomposition:
- Package mem_pkg holds:
  - the state enum (IDLE/ACCESS/DONE);
  - the default constants for DATA_WIDTH, ADDR_BITS and WAIT_STATES;
  - the counter width (4 bits).
- Sub-module mem_array:
  - single-port array of DEPTH x DATA_WIDTH;
  - synchronous write enable and registered read;
  - no reset;
  - instantiated once by mem_subsystem, which owns the FSM, latches, counter and bounds logic.

Test Plan:
- Reset: drive clear=1 for 2 cycles with strobes high -> mem_rdata=0, ready=0, busy=0, err=0; no access starts while clear is high.
- Write timing (WAIT_STATES=2): write 0x000000A5 to addr 0x54 -> busy rises the cycle after sampling, ready rises 3 edges after the sampling edge and holds while the strobe is high; drop the strobe -> ready and busy fall next edge.
- Read back: read addr 0x54 -> mem_rdata=0x000000A5 coincident with ready; the value is still held after a later write of 0x11111111 to 0x55.
- Write priority: read=write=1, addr 0x10, wdata 0xDEADBEEF -> mem_rdata unchanged; a subsequent read of 0x10 returns 0xDEADBEEF.
- Abort: write 0x12345678 to 0x20 (prior content 0xCAFEF00D), pulse clear during ACCESS -> FSM returns to IDLE; a read of 0x20 returns 0xCAFEF00D.
- Bounds: read addr 0x00000254. With MEM_BOUNDS_EN: err=1 in DONE and rdata=0x00000000. Without it: err=0 and rdata=0x000000A5 (aliases 0x54).
